stream_prefetch_ctrl: RTL and testbench
=======================================

Name: stream_prefetch_ctrl

Overview:
- Upstream control stage for stream_buffer in the cache refill path.
- Accepts line-miss requests (label = tag+index) from the cache miss handler and drives stream_buffer's addr/addr_rdy.
- Returns the matching line to the cache.
- After each served miss, issues a sequential next-line prefetch (label+1).

Parameters:
- LINE_WIDTH, 256, cache line width in bits; must match stream_buffer.
- LABEL_WIDTH, 27, line label width (physical address width 32 minus log2(LINE_WIDTH/8)).
- PREFETCH_EN, 1, 1 = issue label+1 prefetch after each response; 0 = demand-only.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- miss_label  in  LABEL_WIDTH  label of the missing line.
- miss_vld  in  1  miss request valid; held until accepted.
- miss_rdy  out  1  ready to accept a miss (high only in IDLE).
- line_data  out  LINE_WIDTH  line returned to the cache.
- line_label  out  LABEL_WIDTH  label of line_data.
- line_vld  out  1  one-cycle pulse; line_data/line_label valid.
- sb_addr  out  LABEL_WIDTH  request label to stream_buffer (addr).
- sb_addr_rdy  out  1  one-cycle request pulse to stream_buffer.
- sb_label  in  LABEL_WIDTH  label held by stream_buffer.
- sb_data  in  LINE_WIDTH  line held by stream_buffer.
- sb_data_vld  in  1  stream_buffer line valid.
- hit_cnt  out  32  count of misses served from buffer or in-flight prefetch.
- miss_cnt  out  32  count of demand fetches issued.

Behaviour:
- Reset:
  - state=IDLE, miss_rdy=1.
  - line_vld=0, sb_addr_rdy=0, line_data=0, line_label=0, sb_addr=0.
  - pf_inflight=0, pf_label=0, hit_cnt=0, miss_cnt=0.
  - Reset mid-operation abandons all state; stream_buffer shares rst.
- Handshake: miss accepted on a cycle with miss_vld && miss_rdy; label latched into req_label.
- In-flight tracking:
  - pf_inflight is set whenever sb_addr_rdy pulses; pf_label <= sb_addr.
  - Clears on any cycle, not the issue cycle, with sb_data_vld && sb_label==pf_label.
- FSM states: IDLE, FETCH, WAIT, DRAIN, RESP.
  - IDLE, hit (sb_data_vld && sb_label==miss_label && !pf_inflight): capture sb_data into line_data, go RESP, hit_cnt+1.
  - IDLE, in-flight match (pf_inflight && pf_label==miss_label): go WAIT without re-issue, hit_cnt+1.
  - IDLE, pf_inflight with different label: go DRAIN.
  - IDLE, otherwise: go FETCH.
  - DRAIN: wait until pf_inflight clears, then go FETCH. The drained line is discarded even if its label happens to match.
  - FETCH: sb_addr=req_label, sb_addr_rdy=1 for exactly one cycle, miss_cnt+1, go WAIT.
  - WAIT: on sb_data_vld && sb_label==req_label (never sampled in the issue cycle), capture line, go RESP. Mismatching or stale data is ignored.
  - RESP: line_vld=1 for one cycle with line_label=req_label. If PREFETCH_EN, the same cycle pulses sb_addr_rdy with sb_addr=req_label+1. Go IDLE.
- Arithmetic: label+1 wraps modulo 2^LABEL_WIDTH (all-ones -> 0). Counters wrap at 2^32.
- Latency (accept at cycle T):
  - Buffer hit: line_vld at T+1.
  - Demand fetch: sb_addr_rdy at T+1; line_vld one cycle after the matching sb_data_vld.
- Single outstanding stream_buffer request at all times.
  - sb_addr_rdy is never asserted while pf_inflight=1, except in the same cycle pf_inflight clears.
- line_data/line_label hold their last value when line_vld=0.

Test Plan:
- Cold miss, buffer empty, miss_label=0x0000100:
  - -> sb_addr_rdy pulse with sb_addr=0x0000100 at T+1; line_vld with memory line 0x100 after the fill.
  - -> prefetch pulse sb_addr=0x0000101 in the RESP cycle; miss_cnt=1, hit_cnt=0.
- Sequential stream, misses 0x100..0x107 back-to-back:
  - -> first is a fetch, remaining 7 are hits or in-flight matches, all eight lines correct.
  - -> hit_cnt=7, miss_cnt=1.
- Non-sequential miss 0x200 while prefetch 0x101 is in flight:
  - -> DRAIN until 0x101 lands (line not returned), then fetch 0x200.
  - -> line_vld only for 0x200.
- Wrap: miss_label=0x7FFFFFF with PREFETCH_EN=1 -> prefetch sb_addr=0x0000000.
- Stale buffer (sb_data_vld=1, sb_label=0x050), miss 0x051 -> no hit; fetch issued; stale data never returned.
- Reset asserted during WAIT -> next cycle: miss_rdy=1, line_vld=0, sb_addr_rdy=0, counters 0; a new miss after reset completes normally.

Source files
------------

// File: rtl/stream_prefetch_ctrl.sv
// Cache-side control stage for stream_buffer: serves line misses from the buffer
// or by demand fetch, then issues a sequential next-line prefetch.
module stream_prefetch_ctrl #(
  parameter int unsigned LINE_WIDTH  = 256,
  parameter int unsigned LABEL_WIDTH = 27,
  parameter bit          PREFETCH_EN = 1'b1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [LABEL_WIDTH-1:0] i_miss_label,
  input  logic                   i_miss_vld,
  output logic                   o_miss_rdy,
  output logic [LINE_WIDTH-1:0]  o_line_data,
  output logic [LABEL_WIDTH-1:0] o_line_label,
  output logic                   o_line_vld,
  output logic [LABEL_WIDTH-1:0] o_sb_addr,
  output logic                   o_sb_addr_rdy,
  input  logic [LABEL_WIDTH-1:0] i_sb_label,
  input  logic [LINE_WIDTH-1:0]  i_sb_data,
  input  logic                   i_sb_data_vld,
  output logic [31:0]            o_hit_cnt,
  output logic [31:0]            o_miss_cnt
);

  localparam int unsigned CNT_WIDTH = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t                 r_state;
  logic                   r_miss_rdy;
  logic [LABEL_WIDTH-1:0] r_req_label;
  logic [LINE_WIDTH-1:0]  r_line_data;
  logic [LABEL_WIDTH-1:0] r_line_label;
  logic                   r_line_vld;
  logic [LABEL_WIDTH-1:0] r_sb_addr;
  logic                   r_sb_addr_rdy;
  logic                   r_pf_inflight;
  logic [LABEL_WIDTH-1:0] r_pf_label;
  logic [CNT_WIDTH-1:0]   r_hit_cnt;
  logic [CNT_WIDTH-1:0]   r_miss_cnt;

  logic w_accept;
  logic w_sb_hit;
  logic w_pf_match;
  logic w_pf_clear;
  logic w_wait_match;

  assign w_accept     = i_miss_vld && r_miss_rdy;
  assign w_sb_hit     = i_sb_data_vld && (i_sb_label == i_miss_label) && !r_pf_inflight;
  assign w_pf_match   = r_pf_inflight && (r_pf_label == i_miss_label);
  // The outstanding request lands; never in the cycle it is issued.
  assign w_pf_clear   = r_pf_inflight && !r_sb_addr_rdy && i_sb_data_vld &&
                        (i_sb_label == r_pf_label);
  assign w_wait_match = i_sb_data_vld && (i_sb_label == r_req_label);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_miss_rdy    <= 1'b1;
      r_req_label   <= '0;
      r_line_data   <= '0;
      r_line_label  <= '0;
      r_line_vld    <= 1'b0;
      r_sb_addr     <= '0;
      r_sb_addr_rdy <= 1'b0;
      r_pf_inflight <= 1'b0;
      r_pf_label    <= '0;
      r_hit_cnt     <= '0;
      r_miss_cnt    <= '0;
    end else begin
      r_line_vld    <= 1'b0;
      r_sb_addr_rdy <= 1'b0;

      if (r_sb_addr_rdy) begin
        r_pf_inflight <= 1'b1;
        r_pf_label    <= r_sb_addr;
      end else if (w_pf_clear) begin
        r_pf_inflight <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_req_label <= i_miss_label;
            r_miss_rdy  <= 1'b0;
            if (w_sb_hit) begin
              r_line_data  <= i_sb_data;
              r_line_label <= i_miss_label;
              r_line_vld   <= 1'b1;
              r_hit_cnt    <= r_hit_cnt + CNT_WIDTH'(1);
              if (PREFETCH_EN) begin
                r_sb_addr     <= i_miss_label + LABEL_WIDTH'(1);
                r_sb_addr_rdy <= 1'b1;
              end
              r_state <= S_RESP;
            end else if (w_pf_match) begin
              r_hit_cnt <= r_hit_cnt + CNT_WIDTH'(1);
              r_state   <= S_WAIT;
            end else if (r_pf_inflight) begin
              r_state <= S_DRAIN;
            end else begin
              r_sb_addr     <= i_miss_label;
              r_sb_addr_rdy <= 1'b1;
              r_state       <= S_FETCH;
            end
          end
        end
        // Unrelated prefetch must land (and is discarded) before our fetch goes out.
        S_DRAIN: begin
          if (!r_pf_inflight || w_pf_clear) begin
            r_sb_addr     <= r_req_label;
            r_sb_addr_rdy <= 1'b1;
            r_state       <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_miss_cnt <= r_miss_cnt + CNT_WIDTH'(1);
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (w_wait_match) begin
            r_line_data  <= i_sb_data;
            r_line_label <= r_req_label;
            r_line_vld   <= 1'b1;
            if (PREFETCH_EN) begin
              r_sb_addr     <= r_req_label + LABEL_WIDTH'(1);
              r_sb_addr_rdy <= 1'b1;
            end
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_miss_rdy <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: begin
          r_miss_rdy <= 1'b1;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign o_miss_rdy    = r_miss_rdy;
  assign o_line_data   = r_line_data;
  assign o_line_label  = r_line_label;
  assign o_line_vld    = r_line_vld;
  assign o_sb_addr     = r_sb_addr;
  assign o_sb_addr_rdy = r_sb_addr_rdy;
  assign o_hit_cnt     = r_hit_cnt;
  assign o_miss_cnt    = r_miss_cnt;

endmodule

// File: tb/tb_stream_prefetch_ctrl.sv
// Directed bench for stream_prefetch_ctrl with a fixed-latency stream_buffer model.
module tb_stream_prefetch_ctrl;

  localparam int unsigned LW  = 27;
  localparam int unsigned DW  = 256;
  localparam int          LAT = 4;

  logic          clk;
  logic          i_rst;
  logic [LW-1:0] i_miss_label;
  logic          i_miss_vld;
  logic          o_miss_rdy;
  logic [DW-1:0] o_line_data;
  logic [LW-1:0] o_line_label;
  logic          o_line_vld;
  logic [LW-1:0] o_sb_addr;
  logic          o_sb_addr_rdy;
  logic [LW-1:0] m_label;
  logic [DW-1:0] m_data;
  logic          m_vld;
  logic [31:0]   o_hit_cnt;
  logic [31:0]   o_miss_cnt;

  logic          m_busy;
  int            m_cnt;
  logic [LW-1:0] m_addr;
  logic          pre_en;
  logic [LW-1:0] pre_label;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [LW-1:0] lv_label_q[$];
  logic [DW-1:0] lv_data_q[$];
  int            lv_cyc_q[$];
  logic [LW-1:0] sa_addr_q[$];
  int            sa_cyc_q[$];

  stream_prefetch_ctrl #(.LINE_WIDTH(DW), .LABEL_WIDTH(LW), .PREFETCH_EN(1'b1)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_miss_label(i_miss_label), .i_miss_vld(i_miss_vld), .o_miss_rdy(o_miss_rdy),
    .o_line_data(o_line_data), .o_line_label(o_line_label), .o_line_vld(o_line_vld),
    .o_sb_addr(o_sb_addr), .o_sb_addr_rdy(o_sb_addr_rdy),
    .i_sb_label(m_label), .i_sb_data(m_data), .i_sb_data_vld(m_vld),
    .o_hit_cnt(o_hit_cnt), .o_miss_cnt(o_miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem_line(input logic [LW-1:0] lbl);
    logic [DW-1:0] v;
    for (int w = 0; w < 8; w++) v[w*32 +: 32] = {5'(w), lbl} ^ 32'h5A00_0000;
    return v;
  endfunction

  // Memory + stream_buffer: holds the last line, new line appears LAT+1 cycles after a request.
  always @(posedge clk) begin
    if (i_rst) begin
      m_vld <= 1'b0; m_label <= '0; m_data <= '0;
      m_busy <= 1'b0; m_cnt <= 0; m_addr <= '0;
    end else if (o_sb_addr_rdy) begin
      m_busy <= 1'b1; m_cnt <= LAT; m_addr <= o_sb_addr;
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        m_busy <= 1'b0; m_vld <= 1'b1; m_label <= m_addr; m_data <= mem_line(m_addr);
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (pre_en) begin
      m_vld <= 1'b1; m_label <= pre_label; m_data <= mem_line(pre_label);
    end
  end

  always @(negedge clk) begin
    if (o_line_vld) begin
      lv_label_q.push_back(o_line_label); lv_data_q.push_back(o_line_data); lv_cyc_q.push_back(cyc);
    end
    if (o_sb_addr_rdy) begin
      sa_addr_q.push_back(o_sb_addr); sa_cyc_q.push_back(cyc);
    end
  end

  function automatic logic [LW-1:0] sa_addr_at(input int i);
    return (i < sa_addr_q.size()) ? sa_addr_q[i] : 'x;
  endfunction
  function automatic int sa_cyc_at(input int i);
    return (i < sa_cyc_q.size()) ? sa_cyc_q[i] : -1;
  endfunction
  function automatic logic [LW-1:0] lv_label_at(input int i);
    return (i < lv_label_q.size()) ? lv_label_q[i] : 'x;
  endfunction
  function automatic logic [DW-1:0] lv_data_at(input int i);
    return (i < lv_data_q.size()) ? lv_data_q[i] : 'x;
  endfunction
  function automatic int lv_cyc_at(input int i);
    return (i < lv_cyc_q.size()) ? lv_cyc_q[i] : -1;
  endfunction

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_miss_vld = 1'b0; i_miss_label = '0; pre_en = 1'b0; pre_label = '0;
    tick(); tick();
    i_rst = 1'b0;
    tick();
  endtask

  task automatic send_miss(input logic [LW-1:0] lbl, output int acc, output bit ok);
    int n;
    n = 0;
    tick();
    i_miss_label = lbl; i_miss_vld = 1'b1;
    while (!o_miss_rdy && n < 100) begin tick(); n++; end
    ok = o_miss_rdy;
    tick();
    acc = cyc;
    i_miss_vld = 1'b0;
  endtask

  task automatic wait_line(input int base, output bit ok);
    int n;
    n = 0;
    while (lv_label_q.size() <= base && n < 100) begin tick(); n++; end
    ok = (lv_label_q.size() > base);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (o_miss_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_miss_rdy: got %b want 1", o_miss_rdy); end
    n_cmp++; if (o_line_vld !== 1'b0) begin n_bad++; $display("FAIL reset_line_vld: got %b want 0", o_line_vld); end
    n_cmp++; if (o_sb_addr_rdy !== 1'b0) begin n_bad++; $display("FAIL reset_sb_addr_rdy: got %b want 0", o_sb_addr_rdy); end
    n_cmp++; if (o_line_data !== '0) begin n_bad++; $display("FAIL reset_line_data: got %h want 0", o_line_data); end
    n_cmp++; if (o_line_label !== '0) begin n_bad++; $display("FAIL reset_line_label: got %h want 0", o_line_label); end
    n_cmp++; if (o_sb_addr !== '0) begin n_bad++; $display("FAIL reset_sb_addr: got %h want 0", o_sb_addr); end
    n_cmp++; if (o_hit_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_hit_cnt: got %0d want 0", o_hit_cnt); end
    n_cmp++; if (o_miss_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_miss_cnt: got %0d want 0", o_miss_cnt); end
  endtask

  task automatic test_cold_miss();
    int lb, sb, acc;
    bit ok1, ok2;
    do_reset();
    lb = lv_label_q.size(); sb = sa_addr_q.size();
    send_miss(27'h0000100, acc, ok1);
    wait_line(lb, ok2);
    tick();
    n_cmp++; if ((ok1 && ok2) !== 1'b1) begin n_bad++; $display("FAIL cold_timeout: got %b want 1", ok1 && ok2); end
    n_cmp++; if (sa_addr_at(sb) !== 27'h0000100) begin n_bad++; $display("FAIL cold_fetch_addr: got %h want 0000100", sa_addr_at(sb)); end
    n_cmp++; if (sa_cyc_at(sb) !== acc) begin n_bad++; $display("FAIL cold_fetch_cycle: got %0d want %0d", sa_cyc_at(sb), acc); end
    n_cmp++; if (lv_label_at(lb) !== 27'h0000100) begin n_bad++; $display("FAIL cold_line_label: got %h want 0000100", lv_label_at(lb)); end
    n_cmp++; if (lv_data_at(lb) !== mem_line(27'h0000100)) begin n_bad++; $display("FAIL cold_line_data: got %h want %h", lv_data_at(lb), mem_line(27'h0000100)); end
    n_cmp++; if (lv_cyc_at(lb) !== acc + LAT + 2) begin n_bad++; $display("FAIL cold_line_cycle: got %0d want %0d", lv_cyc_at(lb), acc + LAT + 2); end
    n_cmp++; if (sa_addr_at(sb + 1) !== 27'h0000101) begin n_bad++; $display("FAIL cold_pf_addr: got %h want 0000101", sa_addr_at(sb + 1)); end
    n_cmp++; if (sa_cyc_at(sb + 1) !== lv_cyc_at(lb)) begin n_bad++; $display("FAIL cold_pf_cycle: got %0d want %0d", sa_cyc_at(sb + 1), lv_cyc_at(lb)); end
    n_cmp++; if (o_miss_cnt !== 32'd1) begin n_bad++; $display("FAIL cold_miss_cnt: got %0d want 1", o_miss_cnt); end
    n_cmp++; if (o_hit_cnt !== 32'd0) begin n_bad++; $display("FAIL cold_hit_cnt: got %0d want 0", o_hit_cnt); end
  endtask

  task automatic test_buffer_hit();
    int lb, sb, acc;
    bit ok1, ok2;
    do_reset();
    send_miss(27'h0000100, acc, ok1);
    wait_line(lv_label_q.size() - 0, ok2);
    repeat (10) tick();
    lb = lv_label_q.size(); sb = sa_addr_q.size();
    send_miss(27'h0000101, acc, ok1);
    tick();
    n_cmp++; if (lv_cyc_at(lb) !== acc) begin n_bad++; $display("FAIL hit_line_cycle: got %0d want %0d", lv_cyc_at(lb), acc); end
    n_cmp++; if (lv_label_at(lb) !== 27'h0000101) begin n_bad++; $display("FAIL hit_line_label: got %h want 0000101", lv_label_at(lb)); end
    n_cmp++; if (lv_data_at(lb) !== mem_line(27'h0000101)) begin n_bad++; $display("FAIL hit_line_data: got %h want %h", lv_data_at(lb), mem_line(27'h0000101)); end
    n_cmp++; if (sa_addr_at(sb) !== 27'h0000102) begin n_bad++; $display("FAIL hit_pf_addr: got %h want 0000102", sa_addr_at(sb)); end
    n_cmp++; if (sa_cyc_at(sb) !== acc) begin n_bad++; $display("FAIL hit_pf_cycle: got %0d want %0d", sa_cyc_at(sb), acc); end
    n_cmp++; if ({o_hit_cnt, o_miss_cnt} !== {32'd1, 32'd1}) begin n_bad++; $display("FAIL hit_counts: got hit=%0d miss=%0d want 1/1", o_hit_cnt, o_miss_cnt); end
  endtask

  task automatic test_back_to_back();
    int lb, acc;
    bit ok1, ok2, all_ok;
    logic [LW-1:0] exp_lbl;
    do_reset();
    lb = lv_label_q.size();
    all_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_miss(27'h0000100 + LW'(i), acc, ok1);
      wait_line(lb + i, ok2);
      all_ok = all_ok && ok1 && ok2;
    end
    tick();
    n_cmp++; if (all_ok !== 1'b1) begin n_bad++; $display("FAIL seq_timeout: got %b want 1", all_ok); end
    for (int i = 0; i < 8; i++) begin
      exp_lbl = 27'h0000100 + LW'(i);
      n_cmp++; if (lv_label_at(lb + i) !== exp_lbl) begin n_bad++; $display("FAIL seq_label[%0d]: got %h want %h", i, lv_label_at(lb + i), exp_lbl); end
      n_cmp++; if (lv_data_at(lb + i) !== mem_line(exp_lbl)) begin n_bad++; $display("FAIL seq_data[%0d]: got %h want %h", i, lv_data_at(lb + i), mem_line(exp_lbl)); end
    end
    n_cmp++; if (o_hit_cnt !== 32'd7) begin n_bad++; $display("FAIL seq_hit_cnt: got %0d want 7", o_hit_cnt); end
    n_cmp++; if (o_miss_cnt !== 32'd1) begin n_bad++; $display("FAIL seq_miss_cnt: got %0d want 1", o_miss_cnt); end
  endtask

  task automatic test_drain();
    int lb, sb, acc, pf_cyc;
    bit ok1, ok2, ok3;
    do_reset();
    send_miss(27'h0000100, acc, ok1);
    wait_line(lv_label_q.size(), ok2);
    pf_cyc = lv_cyc_q[lv_cyc_q.size() - 1];
    lb = lv_label_q.size(); sb = sa_addr_q.size();
    send_miss(27'h0000200, acc, ok1);
    wait_line(lb, ok3);
    repeat (4) tick();
    n_cmp++; if ((ok1 && ok2 && ok3) !== 1'b1) begin n_bad++; $display("FAIL drain_timeout: got %b want 1", ok1 && ok2 && ok3); end
    n_cmp++; if (lv_label_q.size() !== lb + 1) begin n_bad++; $display("FAIL drain_line_count: got %0d want %0d", lv_label_q.size() - lb, 1); end
    n_cmp++; if (lv_label_at(lb) !== 27'h0000200) begin n_bad++; $display("FAIL drain_line_label: got %h want 0000200", lv_label_at(lb)); end
    n_cmp++; if (lv_data_at(lb) !== mem_line(27'h0000200)) begin n_bad++; $display("FAIL drain_line_data: got %h want %h", lv_data_at(lb), mem_line(27'h0000200)); end
    n_cmp++; if (sa_addr_at(sb) !== 27'h0000200) begin n_bad++; $display("FAIL drain_fetch_addr: got %h want 0000200", sa_addr_at(sb)); end
    n_cmp++; if (sa_cyc_at(sb) !== pf_cyc + LAT + 2) begin n_bad++; $display("FAIL drain_fetch_cycle: got %0d want %0d", sa_cyc_at(sb), pf_cyc + LAT + 2); end
    n_cmp++; if ({o_hit_cnt, o_miss_cnt} !== {32'd0, 32'd2}) begin n_bad++; $display("FAIL drain_counts: got hit=%0d miss=%0d want 0/2", o_hit_cnt, o_miss_cnt); end
  endtask

  task automatic test_wrap();
    int lb, sb, acc;
    bit ok1, ok2;
    do_reset();
    lb = lv_label_q.size(); sb = sa_addr_q.size();
    send_miss(27'h7FFFFFF, acc, ok1);
    wait_line(lb, ok2);
    tick();
    n_cmp++; if (lv_label_at(lb) !== 27'h7FFFFFF) begin n_bad++; $display("FAIL wrap_line_label: got %h want 7ffffff", lv_label_at(lb)); end
    n_cmp++; if (sa_addr_at(sb + 1) !== 27'h0000000) begin n_bad++; $display("FAIL wrap_pf_addr: got %h want 0000000", sa_addr_at(sb + 1)); end
    n_cmp++; if (sa_cyc_at(sb + 1) !== lv_cyc_at(lb)) begin n_bad++; $display("FAIL wrap_pf_cycle: got %0d want %0d", sa_cyc_at(sb + 1), lv_cyc_at(lb)); end
  endtask

  task automatic test_stale();
    int lb, sb, acc;
    bit ok1, ok2;
    do_reset();
    pre_label = 27'h0000050; pre_en = 1'b1;
    tick();
    pre_en = 1'b0;
    tick();
    lb = lv_label_q.size(); sb = sa_addr_q.size();
    send_miss(27'h0000051, acc, ok1);
    wait_line(lb, ok2);
    repeat (3) tick();
    n_cmp++; if (sa_addr_at(sb) !== 27'h0000051) begin n_bad++; $display("FAIL stale_fetch_addr: got %h want 0000051", sa_addr_at(sb)); end
    n_cmp++; if (sa_cyc_at(sb) !== acc) begin n_bad++; $display("FAIL stale_fetch_cycle: got %0d want %0d", sa_cyc_at(sb), acc); end
    n_cmp++; if (lv_label_q.size() !== lb + 1) begin n_bad++; $display("FAIL stale_line_count: got %0d want 1", lv_label_q.size() - lb); end
    n_cmp++; if (lv_label_at(lb) !== 27'h0000051) begin n_bad++; $display("FAIL stale_line_label: got %h want 0000051", lv_label_at(lb)); end
    n_cmp++; if (lv_data_at(lb) !== mem_line(27'h0000051)) begin n_bad++; $display("FAIL stale_line_data: got %h want %h", lv_data_at(lb), mem_line(27'h0000051)); end
    n_cmp++; if ({o_hit_cnt, o_miss_cnt} !== {32'd0, 32'd1}) begin n_bad++; $display("FAIL stale_counts: got hit=%0d miss=%0d want 0/1", o_hit_cnt, o_miss_cnt); end
  endtask

  task automatic test_reset_mid();
    int lb, acc;
    bit ok1, ok2;
    do_reset();
    lb = lv_label_q.size();
    send_miss(27'h0000300, acc, ok1);
    tick(); tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    n_cmp++; if (o_miss_rdy !== 1'b1) begin n_bad++; $display("FAIL rstmid_miss_rdy: got %b want 1", o_miss_rdy); end
    n_cmp++; if (o_line_vld !== 1'b0) begin n_bad++; $display("FAIL rstmid_line_vld: got %b want 0", o_line_vld); end
    n_cmp++; if (o_sb_addr_rdy !== 1'b0) begin n_bad++; $display("FAIL rstmid_sb_addr_rdy: got %b want 0", o_sb_addr_rdy); end
    n_cmp++; if (o_sb_addr !== '0) begin n_bad++; $display("FAIL rstmid_sb_addr: got %h want 0", o_sb_addr); end
    n_cmp++; if ({o_hit_cnt, o_miss_cnt} !== 64'd0) begin n_bad++; $display("FAIL rstmid_counts: got hit=%0d miss=%0d want 0/0", o_hit_cnt, o_miss_cnt); end
    send_miss(27'h0000301, acc, ok1);
    wait_line(lb, ok2);
    repeat (3) tick();
    n_cmp++; if (lv_label_q.size() !== lb + 1) begin n_bad++; $display("FAIL rstmid_line_count: got %0d want 1", lv_label_q.size() - lb); end
    n_cmp++; if (lv_label_at(lb) !== 27'h0000301) begin n_bad++; $display("FAIL rstmid_line_label: got %h want 0000301", lv_label_at(lb)); end
    n_cmp++; if (lv_data_at(lb) !== mem_line(27'h0000301)) begin n_bad++; $display("FAIL rstmid_line_data: got %h want %h", lv_data_at(lb), mem_line(27'h0000301)); end
    n_cmp++; if (o_miss_cnt !== 32'd1) begin n_bad++; $display("FAIL rstmid_miss_cnt: got %0d want 1", o_miss_cnt); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_cold_miss();
    test_buffer_hit();
    test_back_to_back();
    test_drain();
    test_wrap();
    test_stale();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
